// File: rtl/mux4_rr_arbiter_pkg.sv
// mux_arb_pkg: shared constants, FSM states and round-robin pick helper for the arbiter
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First requester found when scanning from ptr upward, wrapping 3 -> 0.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
        pick_t            p;
        logic [IDX_W-1:0] i;
        p = '0;
        // Walk from the farthest candidate back to ptr so the nearest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            i = ptr + IDX_W'(k);
            if (req[i]) begin
                p.found = 1'b1;
                p.idx   = i;
            end
        end
        return p;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// mux4_rr_arbiter_mux: one-bit 4:1 select, instantiated once per data bit slice
module mux4_rr_arbiter_mux (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = d[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sequencing four requesters onto one shared 4:1 mux
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*WIDTH-1:0] datos_in,
    output logic [N_REQ-1:0]   grant,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         hold_q, hold_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   m;
    pick_t              pick;
    logic               tenure_end;

    // Each bit slice gets its own 4:1 mux; all share the registered select.
    for (genvar j = 0; j < WIDTH; j++) begin : g_slice
        mux4_rr_arbiter_mux u_mux (
            .d   ({datos_in[3*WIDTH+j], datos_in[2*WIDTH+j], datos_in[WIDTH+j], datos_in[j]}),
            .sel (sel_q),
            .y   (m[j])
        );
    end

    assign busy       = (state_q == GRANT);
    assign grant      = grant_q;
    assign sel        = sel_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;

    // Arbitration: keep the owner until it drops or its tenure expires, otherwise re-pick from ptr.
    always_comb begin
        pick       = rr_pick(req, ptr_q);
        tenure_end = !req[sel_q] || (hold_q == HOLD_LAST);
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        if (state_q == GRANT && !tenure_end) begin
            hold_d = hold_q + 4'd1;
        end else if (pick.found) begin
            state_d = GRANT;
            grant_d = onehot(pick.idx);
            sel_d   = pick.idx;
            ptr_d   = pick.idx + IDX_W'(1);
            hold_d  = '0;
        end else begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
        end
        data_d  = busy ? m : '0;
        valid_d = busy;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench comparing two arbiter instances (MAX_HOLD 4 and 1) against a tenure-level model
module tb_mux4_rr_arbiter;

    localparam int W = 3;

    typedef struct packed {
        logic [3:0]   grant;
        logic [1:0]   sel;
        logic         busy;
        logic [W-1:0] dout;
        logic         dv;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req = '0;
    logic [4*W-1:0] datos = '0;

    logic [3:0]   grant0, grant1;
    logic [1:0]   sel0, sel1;
    logic         busy0, busy1, dv0, dv1;
    logic [W-1:0] dout0, dout1;

    exp_t q0[$];
    exp_t q1[$];

    int owner[2] = '{-1, -1};
    int ten[2]   = '{0, 0};
    int ptr[2]   = '{0, 0};
    int msel[2]  = '{0, 0};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .datos_in(datos),
        .grant(grant0), .sel(sel0), .busy(busy0), .data_out(dout0), .data_valid(dv0)
    );

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .datos_in(datos),
        .grant(grant1), .sel(sel1), .busy(busy1), .data_out(dout1), .data_valid(dv1)
    );

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Tenure-level model: an owner keeps the mux for up to hold_of(d) cycles while it requests.
    task automatic step_model(input int d, input logic r, input logic [3:0] rq, output exp_t e);
        int i;
        e.dv   = (owner[d] >= 0);
        e.dout = (owner[d] >= 0) ? datos[msel[d]*W +: W] : '0;
        if (!r) begin
            owner[d] = -1;
            ten[d]   = 0;
            ptr[d]   = 0;
            msel[d]  = 0;
            e.dout   = '0;
            e.dv     = 1'b0;
        end else if (owner[d] >= 0 && rq[owner[d]] && ten[d] < hold_of(d)) begin
            ten[d]++;
        end else begin
            owner[d] = -1;
            for (int k = 0; k < 4; k++) begin
                i = (ptr[d] + k) % 4;
                if (rq[i] && owner[d] < 0) begin
                    owner[d] = i;
                    ten[d]   = 1;
                    ptr[d]   = (i + 1) % 4;
                    msel[d]  = i;
                end
            end
        end
        e.busy  = (owner[d] >= 0);
        e.grant = (owner[d] >= 0) ? 4'(1 << owner[d]) : 4'b0;
        e.sel   = 2'(msel[d]);
    endtask

    task automatic cyc(input logic r, input logic [3:0] rq);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        datos = (4*W)'($urandom);
        step_model(0, r, rq, e);
        q0.push_back(e);
        step_model(1, r, rq, e);
        q1.push_back(e);
    endtask

    task automatic rep(input logic r, input logic [3:0] rq, input int n);
        for (int k = 0; k < n; k++) cyc(r, rq);
    endtask

    // Monitor: after every edge, pop the expected response for each instance and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("grant", 0, 32'(grant0), 32'(e.grant));
            chk("sel", 0, 32'(sel0), 32'(e.sel));
            chk("busy", 0, 32'(busy0), 32'(e.busy));
            chk("data_out", 0, 32'(dout0), 32'(e.dout));
            chk("data_valid", 0, 32'(dv0), 32'(e.dv));
            chk("grant_onehot0", 0, 32'($onehot0(grant0)), 32'd1);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("grant", 1, 32'(grant1), 32'(e.grant));
            chk("sel", 1, 32'(sel1), 32'(e.sel));
            chk("busy", 1, 32'(busy1), 32'(e.busy));
            chk("data_out", 1, 32'(dout1), 32'(e.dout));
            chk("data_valid", 1, 32'(dv1), 32'(e.dv));
            chk("grant_onehot0", 1, 32'($onehot0(grant1)), 32'd1);
        end
    end

    initial begin
        logic [3:0] rq;
        logic       r;
        rep(1'b0, 4'b1111, 3);
        rep(1'b1, 4'b1111, 2);
        rep(1'b0, 4'b0000, 1);
        rep(1'b1, 4'b0100, 10);
        rep(1'b0, 4'b0000, 1);
        rep(1'b1, 4'b1111, 20);
        rep(1'b1, 4'b0000, 2);
        rep(1'b0, 4'b0000, 1);
        rep(1'b1, 4'b1001, 2);
        rep(1'b1, 4'b1000, 3);
        rep(1'b0, 4'b0000, 1);
        rep(1'b1, 4'b1000, 2);
        rep(1'b1, 4'b0011, 8);
        rep(1'b0, 4'b0000, 1);
        rep(1'b1, 4'b0100, 2);
        rep(1'b1, 4'b0110, 1);
        rep(1'b0, 4'b0110, 1);
        rep(1'b1, 4'b0110, 3);
        rq = '0;
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
            cyc(r, rq);
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d/%0d entries expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 multiplexer datapath among four requesters. It grants one requester at a time and drives the mux select from the winner's index. It bounds each tenure to MAX_HOLD cycles and registers the selected data with a valid flag. It sits in front of the CPU's shared 4:1 select path, replacing free-running select stepping with request-driven sequencing.

Parameters:
WIDTH, 1, bit width of each requester's data lane (datos_in is 4*WIDTH bits).
MAX_HOLD, 4, maximum consecutive cycles one requester may own the mux; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low; sampled on clk rising edge.
req  input  4  request per requester; bit i = requester i wants the mux.
datos_in  input  4*WIDTH  lane i = datos_in[i*WIDTH +: WIDTH].
grant  output  4  one-hot owner, registered; 0 when idle.
sel  output  2  owner index driving the mux, registered.
busy  output  1  1 while in GRANT state.
data_out  output  WIDTH  registered mux output.
data_valid  output  1  data_out holds a granted requester's data.

Behaviour:
- Reset (rst_n=0 at an edge, including mid-tenure): grant=0, sel=0, busy=0, data_out=0, data_valid=0, state=IDLE, ptr=0, hold_cnt=0. req is ignored during reset.
- ptr (2 bits) is the highest-priority index. Winner = first i with req[i]=1 scanning ptr, ptr+1, ... mod 4 (wraps 3->0). On every grant, ptr <= winner+1 mod 4.
- IDLE: if req!=0, then at the next edge state<=GRANT, grant<=onehot(winner), sel<=winner, busy<=1, hold_cnt<=0. Latency is 1 cycle from req sampled to grant visible. If req==0, stay; sel holds its last value.
- GRANT, owner c:
  - Tenure continues while req[c]=1 and hold_cnt<MAX_HOLD-1; hold_cnt increments each cycle.
  - Tenure ends at the edge where req[c]=0 is sampled or hold_cnt==MAX_HOLD-1.
  - At the end, if any other req bit is set, the next winner is granted at that same edge with no IDLE bubble. The scan starts at ptr (=c+1), so c has lowest priority.
  - If only c still requests at expiry, c is re-granted with hold_cnt=0. grant stays constant; there is no gap.
  - If req==0, state<=IDLE, grant<=0, busy<=0.
- MAX_HOLD=1: every tenure lasts one cycle; under saturation the owner rotates every cycle.
- hold_cnt width is 4 bits. It saturates logic-wise at MAX_HOLD-1 and never wraps.
- Datapath: the mux output m = lane[sel] (combinational).
  - Each edge: data_out<=busy ? m : 0 and data_valid<=busy.
  - Data latency is 1 cycle after grant/sel.
- req changing mid-tenure for non-owners only affects the next arbitration. Owner drop is honoured at the next edge.
- grant is always one-hot or zero, and sel==index(grant) whenever busy=1.

Decomposition:
- Package mux_arb_pkg:
  - N_REQ=4 and IDX_W=2.
  - State enum {IDLE, GRANT}.
  - Function rr_pick(req, ptr) returning {found, idx}.
- Sub-module: reuse the existing 4:1 mux unchanged, with WIDTH instances generated per bit slice (datos_in bit j of each lane -> instance j, sel shared). The arbiter FSM stays in the top module.

Test Plan:
1. rst_n=0 for 3 cycles with req=4'b1111, then rst_n=1 -> while in reset grant=0, sel=0, busy=0, data_valid=0; one cycle after release grant=4'b0001, sel=0.
2. MAX_HOLD=4, req=4'b0100 held 10 cycles -> grant=4'b0100, sel=2 every cycle with no gap; data_out equals lane 2 delayed 1 cycle; data_valid=1 throughout.
3. MAX_HOLD=4, req=4'b1111 held 20 cycles -> grant sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001x4; sel 0,1,2,3,0.
4. req=4'b1001, then req[0] dropped after 2 granted cycles -> grant 0001 for 2 cycles, then 1000 next cycle with no IDLE bubble; busy stays 1.
5. While owner=3, req=4'b0011 and req[3] drops -> next grant=4'b0001 (wrap), then after expiry 4'b0010.
6. rst_n=0 for one edge mid-tenure of requester 2 with req=4'b0110 held -> busy=0 and ptr=0 after that edge; after release the first grant=4'b0010 (scan from 0).
